// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU front end.
// Used by the operand collector, its decoder and the ALU checker.
package alu_pkg;

    localparam int ALU_WIDTH     = 8;
    localparam int ALU_CMD_WIDTH = 4;

    typedef logic [1:0] need_t;

    localparam need_t NEED_NONE = 2'b00;
    localparam need_t NEED_A    = 2'b01;
    localparam need_t NEED_B    = 2'b10;
    localparam need_t NEED_AB   = 2'b11;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Arithmetic commands (MODE = 1)
    localparam logic [3:0] A_ADD     = 4'd0;
    localparam logic [3:0] A_SUB     = 4'd1;
    localparam logic [3:0] A_ADD_CIN = 4'd2;
    localparam logic [3:0] A_SUB_CIN = 4'd3;
    localparam logic [3:0] A_INC_A   = 4'd4;
    localparam logic [3:0] A_DEC_A   = 4'd5;
    localparam logic [3:0] A_INC_B   = 4'd6;
    localparam logic [3:0] A_DEC_B   = 4'd7;
    localparam logic [3:0] A_CMP     = 4'd8;
    localparam logic [3:0] A_MUL_INC = 4'd9;
    localparam logic [3:0] A_MUL_SHL = 4'd10;

    // Logical commands (MODE = 0)
    localparam logic [3:0] L_AND    = 4'd0;
    localparam logic [3:0] L_NAND   = 4'd1;
    localparam logic [3:0] L_OR     = 4'd2;
    localparam logic [3:0] L_NOR    = 4'd3;
    localparam logic [3:0] L_XOR    = 4'd4;
    localparam logic [3:0] L_XNOR   = 4'd5;
    localparam logic [3:0] L_NOT_A  = 4'd6;
    localparam logic [3:0] L_NOT_B  = 4'd7;
    localparam logic [3:0] L_SHR1_A = 4'd8;
    localparam logic [3:0] L_SHL1_A = 4'd9;
    localparam logic [3:0] L_SHR1_B = 4'd10;
    localparam logic [3:0] L_SHL1_B = 4'd11;
    localparam logic [3:0] L_ROL    = 4'd12;
    localparam logic [3:0] L_ROR    = 4'd13;

endpackage

// File: rtl/alu_opreq_decode.sv
// Maps (mode, cmd) to the operands the ALU needs; a zero mask
// means the command does not exist.
module alu_opreq_decode
    import alu_pkg::*;
#(
    parameter int CMD_WIDTH = ALU_CMD_WIDTH
) (
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    output need_t                need,
    output logic                 legal
);

    localparam int CW = CMD_WIDTH;

    always_comb begin
        need = NEED_NONE;
        if (mode) begin
            unique case (cmd)
                CW'(A_ADD), CW'(A_SUB), CW'(A_ADD_CIN), CW'(A_SUB_CIN),
                CW'(A_CMP), CW'(A_MUL_INC), CW'(A_MUL_SHL):
                    need = NEED_AB;
                CW'(A_INC_A), CW'(A_DEC_A):
                    need = NEED_A;
                CW'(A_INC_B), CW'(A_DEC_B):
                    need = NEED_B;
                default:
                    need = NEED_NONE;
            endcase
        end else begin
            unique case (cmd)
                CW'(L_AND), CW'(L_NAND), CW'(L_OR), CW'(L_NOR),
                CW'(L_XOR), CW'(L_XNOR), CW'(L_ROL), CW'(L_ROR):
                    need = NEED_AB;
                CW'(L_NOT_A), CW'(L_SHR1_A), CW'(L_SHL1_A):
                    need = NEED_A;
                CW'(L_NOT_B), CW'(L_SHR1_B), CW'(L_SHL1_B):
                    need = NEED_B;
                default:
                    need = NEED_NONE;
            endcase
        end
    end

    assign legal = (need != NEED_NONE);

endmodule

// File: rtl/alu_operand_collector.sv
// Gathers split OPA/OPB beats into one complete ALU command,
// dropping stale partial commands and illegal opcodes.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int CMD_WIDTH = ALU_CMD_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_ce,
    input  logic                 in_mode,
    input  logic [CMD_WIDTH-1:0] in_cmd,
    input  logic [1:0]           in_inp_valid,
    input  logic [WIDTH-1:0]     in_opa,
    input  logic [WIDTH-1:0]     in_opb,
    input  logic                 in_cin,
    output logic                 alu_ce,
    output logic                 alu_mode,
    output logic [CMD_WIDTH-1:0] alu_cmd,
    output logic [1:0]           alu_inp_valid,
    output logic [WIDTH-1:0]     alu_opa,
    output logic [WIDTH-1:0]     alu_opb,
    output logic                 alu_cin,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_cmd
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    need_t                need_q, need_d, mask_q, mask_d;
    logic                 mode_q, mode_d, cin_q, cin_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;

    logic                 ce_q, ce_d, tmo_q, tmo_d, ecmd_q, ecmd_d;
    logic                 omode_q, omode_d, ocin_q, ocin_d;
    logic [CMD_WIDTH-1:0] ocmd_q, ocmd_d;
    need_t                oiv_q, oiv_d;
    logic [WIDTH-1:0]     oa_q, oa_d, ob_q, ob_d;

    need_t                in_need, in_got, w_got, iss_need;
    logic                 in_legal, same, iss, iss_mode, iss_cin;
    logic [CMD_WIDTH-1:0] iss_cmd;
    logic [WIDTH-1:0]     w_opa, w_opb, iss_a, iss_b;

    alu_opreq_decode #(
        .CMD_WIDTH(CMD_WIDTH)
    ) u_dec (
        .mode  (in_mode),
        .cmd   (in_cmd),
        .need  (in_need),
        .legal (in_legal)
    );

    assign in_got = in_inp_valid & in_need;
    assign w_got  = mask_q | (in_inp_valid & need_q);
    assign w_opa  = in_inp_valid[0] ? in_opa : opa_q;
    assign w_opb  = in_inp_valid[1] ? in_opb : opb_q;
    assign same   = (in_mode == mode_q) && (in_cmd == cmd_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        need_d   = need_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        cmd_d    = cmd_q;
        cin_d    = cin_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        tmo_d    = 1'b0;
        ecmd_d   = 1'b0;
        iss      = 1'b0;
        iss_mode = in_mode;
        iss_cmd  = in_cmd;
        iss_cin  = in_cin;
        iss_need = in_need;
        iss_a    = in_opa;
        iss_b    = in_opb;

        unique case (state_q)
            IDLE: begin
                if (in_ce && (in_inp_valid != 2'b00)) begin
                    if (!in_legal) begin
                        ecmd_d = 1'b1;
                    end else if (in_got == in_need) begin
                        iss = 1'b1;
                    end else if (in_got != NEED_NONE) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        need_d  = in_need;
                        mask_d  = in_got;
                        mode_d  = in_mode;
                        cmd_d   = in_cmd;
                        cin_d   = in_cin;
                        opa_d   = in_inp_valid[0] ? in_opa : '0;
                        opb_d   = in_inp_valid[1] ? in_opb : '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A beat for another command means the partial one is stale.
                if (in_ce && !same) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (in_ce && (w_got == need_q)) begin
                    iss      = 1'b1;
                    iss_mode = mode_q;
                    iss_cmd  = cmd_q;
                    iss_cin  = cin_q;
                    iss_need = need_q;
                    iss_a    = w_opa;
                    iss_b    = w_opb;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (in_ce) begin
                    mask_d = w_got;
                    opa_d  = w_opa;
                    opb_d  = w_opb;
                end
            end
            default: state_d = IDLE;
        endcase

        ce_d    = iss;
        omode_d = omode_q;
        ocmd_d  = ocmd_q;
        ocin_d  = ocin_q;
        oiv_d   = oiv_q;
        oa_d    = oa_q;
        ob_d    = ob_q;
        if (iss) begin
            omode_d = iss_mode;
            ocmd_d  = iss_cmd;
            ocin_d  = iss_cin;
            oiv_d   = iss_need;
            oa_d    = iss_need[0] ? iss_a : '0;
            ob_d    = iss_need[1] ? iss_b : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            need_q  <= NEED_NONE;
            mask_q  <= NEED_NONE;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            ce_q    <= 1'b0;
            tmo_q   <= 1'b0;
            ecmd_q  <= 1'b0;
            omode_q <= 1'b0;
            ocmd_q  <= '0;
            ocin_q  <= 1'b0;
            oiv_q   <= NEED_NONE;
            oa_q    <= '0;
            ob_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            need_q  <= need_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ce_q    <= ce_d;
            tmo_q   <= tmo_d;
            ecmd_q  <= ecmd_d;
            omode_q <= omode_d;
            ocmd_q  <= ocmd_d;
            ocin_q  <= ocin_d;
            oiv_q   <= oiv_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
        end
    end

    assign alu_ce        = ce_q;
    assign alu_mode      = omode_q;
    assign alu_cmd       = ocmd_q;
    assign alu_inp_valid = oiv_q;
    assign alu_opa       = oa_q;
    assign alu_opb       = ob_q;
    assign alu_cin       = ocin_q;
    assign busy          = (state_q == WAIT);
    assign err_timeout   = tmo_q;
    assign err_cmd       = ecmd_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: vector table, directed
// multi-cycle sequences and random beats against a cycle model.
module tb_alu_operand_collector;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_ce, in_mode, in_cin;
    logic [CW-1:0] in_cmd;
    logic [1:0]    in_inp_valid;
    logic [W-1:0]  in_opa, in_opb;
    logic          alu_ce, alu_mode, alu_cin;
    logic [CW-1:0] alu_cmd;
    logic [1:0]    alu_inp_valid;
    logic [W-1:0]  alu_opa, alu_opb;
    logic          busy, err_timeout, err_cmd;

    always #5 clk = ~clk;

    alu_operand_collector #(
        .WIDTH(W), .CMD_WIDTH(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_ce(in_ce), .in_mode(in_mode),
        .in_cmd(in_cmd), .in_inp_valid(in_inp_valid),
        .in_opa(in_opa), .in_opb(in_opb), .in_cin(in_cin),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cmd(alu_cmd),
        .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa),
        .alu_opb(alu_opb), .alu_cin(alu_cin), .busy(busy),
        .err_timeout(err_timeout), .err_cmd(err_cmd)
    );

    int    n_run  = 0;
    int    n_fail = 0;
    string phase  = "reset";

    // Operands each command needs: 3 = A+B, 1 = A, 2 = B, 0 = no such command
    logic [1:0] need_ar [16] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] need_lg [16] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2,
                                 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

    // Pending partial command and expected outputs
    bit            p_act = 1'b0;
    logic          p_mode, p_cin;
    logic [CW-1:0] p_cmd;
    logic [W-1:0]  p_a, p_b;
    logic [1:0]    p_have, p_need;
    int            p_age;

    logic          e_ce, e_mode, e_cin, e_busy, e_tmo, e_ecmd;
    logic [CW-1:0] e_cmd;
    logic [1:0]    e_iv;
    logic [W-1:0]  e_a, e_b;

    function automatic logic [1:0] need_of(input logic m, input logic [CW-1:0] c);
        return m ? need_ar[c] : need_lg[c];
    endfunction

    task automatic model_issue(input logic m, input logic [CW-1:0] c, input logic ci,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] n);
        e_ce   = 1'b1;
        e_mode = m;
        e_cmd  = c;
        e_cin  = ci;
        e_iv   = n;
        e_a    = n[0] ? a : '0;
        e_b    = n[1] ? b : '0;
    endtask

    task automatic model_eval();
        logic [1:0] n;
        e_ce   = 1'b0;
        e_tmo  = 1'b0;
        e_ecmd = 1'b0;
        if (!rst) begin
            p_act = 1'b0;
            {e_mode, e_cmd, e_cin, e_iv, e_a, e_b} = '0;
        end else if (!p_act) begin
            if (in_ce && in_inp_valid != 2'b00) begin
                n = need_of(in_mode, in_cmd);
                if (n == 2'b00) begin
                    e_ecmd = 1'b1;
                end else if ((in_inp_valid & n) == n) begin
                    model_issue(in_mode, in_cmd, in_cin, in_opa, in_opb, n);
                end else if ((in_inp_valid & n) != 2'b00) begin
                    p_act  = 1'b1;
                    p_mode = in_mode;
                    p_cmd  = in_cmd;
                    p_cin  = in_cin;
                    p_need = n;
                    p_have = in_inp_valid & n;
                    p_a    = in_inp_valid[0] ? in_opa : '0;
                    p_b    = in_inp_valid[1] ? in_opb : '0;
                    p_age  = 0;
                end
            end
        end else begin
            p_age++;
            if (in_ce && (in_mode != p_mode || in_cmd != p_cmd)) begin
                e_tmo = 1'b1;
                p_act = 1'b0;
            end else begin
                if (in_ce) begin
                    p_have = p_have | (in_inp_valid & p_need);
                    if (in_inp_valid[0]) p_a = in_opa;
                    if (in_inp_valid[1]) p_b = in_opb;
                end
                if (p_have == p_need) begin
                    model_issue(p_mode, p_cmd, p_cin, p_a, p_b, p_need);
                    p_act = 1'b0;
                end else if (p_age >= TO) begin
                    e_tmo = 1'b1;
                    p_act = 1'b0;
                end
            end
        end
        e_busy = p_act;
    endtask

    task automatic check_all();
        logic [27:0] got, exp;
        got = {alu_ce, alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
               alu_cin, busy, err_timeout, err_cmd};
        exp = {e_ce, e_mode, e_cmd, e_iv, e_a, e_b, e_cin, e_busy, e_tmo, e_ecmd};
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs %h, model expects %h", phase, got, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        in_ce = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic beat(input logic m, input logic [CW-1:0] c, input logic [1:0] iv,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        in_ce        = 1'b1;
        in_mode      = m;
        in_cmd       = c;
        in_inp_valid = iv;
        in_opa       = a;
        in_opb       = b;
        in_cin       = ci;
        cyc();
        in_ce = 1'b0;
    endtask

    typedef struct {
        logic          m;
        logic [CW-1:0] c;
        logic [1:0]    iv;
        logic [W-1:0]  a, b;
        logic          cin;
        logic          ce;
        logic [1:0]    eiv;
        logic [W-1:0]  ea, eb;
        logic          ecmd;
    } vec_t;

    vec_t vt [12];

    initial begin
        int bc, t_err;
        logic ce_seen, busy_at;

        vt[0]  = '{1'b1, 4'd0,  2'b11, 8'h12, 8'h34, 1'b0, 1'b1, 2'b11, 8'h12, 8'h34, 1'b0};
        vt[1]  = '{1'b1, 4'd4,  2'b11, 8'h07, 8'h99, 1'b1, 1'b1, 2'b01, 8'h07, 8'h00, 1'b0};
        vt[2]  = '{1'b1, 4'd6,  2'b11, 8'h07, 8'h99, 1'b0, 1'b1, 2'b10, 8'h00, 8'h99, 1'b0};
        vt[3]  = '{1'b1, 4'd7,  2'b10, 8'hAA, 8'h3C, 1'b1, 1'b1, 2'b10, 8'h00, 8'h3C, 1'b0};
        vt[4]  = '{1'b1, 4'd10, 2'b11, 8'h81, 8'h42, 1'b0, 1'b1, 2'b11, 8'h81, 8'h42, 1'b0};
        vt[5]  = '{1'b1, 4'd11, 2'b11, 8'h01, 8'h02, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1};
        vt[6]  = '{1'b0, 4'd13, 2'b11, 8'h5A, 8'hA5, 1'b1, 1'b1, 2'b11, 8'h5A, 8'hA5, 1'b0};
        vt[7]  = '{1'b0, 4'd8,  2'b01, 8'hC3, 8'h77, 1'b0, 1'b1, 2'b01, 8'hC3, 8'h00, 1'b0};
        vt[8]  = '{1'b0, 4'd11, 2'b10, 8'h11, 8'h22, 1'b0, 1'b1, 2'b10, 8'h00, 8'h22, 1'b0};
        vt[9]  = '{1'b0, 4'd14, 2'b01, 8'h33, 8'h44, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1};
        vt[10] = '{1'b1, 4'd5,  2'b10, 8'h55, 8'h66, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vt[11] = '{1'b0, 4'd15, 2'b00, 8'h77, 8'h88, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};

        rst = 1'b0;
        in_ce = 1'b0; in_mode = 1'b0; in_cmd = '0; in_inp_valid = 2'b00;
        in_opa = '0; in_opb = '0; in_cin = 1'b0;

        phase = "reset";
        cyc();
        cyc();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_alu_ce", 32'(alu_ce), 32'd0);
        rst = 1'b1;
        idle(1);

        foreach (vt[i]) begin
            phase = $sformatf("vec%0d", i);
            beat(vt[i].m, vt[i].c, vt[i].iv, vt[i].a, vt[i].b, vt[i].cin);
            chk({phase, "_ce"}, 32'(alu_ce), 32'(vt[i].ce));
            chk({phase, "_errcmd"}, 32'(err_cmd), 32'(vt[i].ecmd));
            chk({phase, "_busy"}, 32'(busy), 32'd0);
            if (vt[i].ce) begin
                chk({phase, "_iv"}, 32'(alu_inp_valid), 32'(vt[i].eiv));
                chk({phase, "_opa"}, 32'(alu_opa), 32'(vt[i].ea));
                chk({phase, "_opb"}, 32'(alu_opb), 32'(vt[i].eb));
                chk({phase, "_cin"}, 32'(alu_cin), 32'(vt[i].cin));
            end
            idle(1);
        end

        phase = "hold";
        beat(1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b0);
        idle(2);
        chk("hold_opa", 32'(alu_opa), 32'h12);
        chk("hold_ce", 32'(alu_ce), 32'd0);

        phase = "split";
        beat(1'b0, 4'd0, 2'b01, 8'hF0, 8'hAA, 1'b1);
        bc = int'(busy);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            bc += int'(busy);
        end
        beat(1'b0, 4'd0, 2'b10, 8'h55, 8'h0F, 1'b0);
        bc += int'(busy);
        chk("split_busy_cycles", 32'(bc), 32'd6);
        chk("split_ce", 32'(alu_ce), 32'd1);
        chk("split_opa", 32'(alu_opa), 32'hF0);
        chk("split_opb", 32'(alu_opb), 32'h0F);
        chk("split_cin_first_beat", 32'(alu_cin), 32'd1);
        idle(1);

        phase = "timeout";
        beat(1'b1, 4'd1, 2'b01, 8'h05, 8'h00, 1'b0);
        t_err = -1;
        ce_seen = 1'b0;
        busy_at = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            idle(1);
            if (alu_ce) ce_seen = 1'b1;
            if (err_timeout && t_err < 0) begin
                t_err = j + 1;
                busy_at = busy;
            end
        end
        chk("timeout_delay", 32'(t_err), 32'd17);
        chk("timeout_no_ce", 32'(ce_seen), 32'd0);
        chk("timeout_busy", 32'(busy_at), 32'd0);

        phase = "last_beat";
        beat(1'b1, 4'd1, 2'b01, 8'h05, 8'h00, 1'b0);
        idle(TO - 1);
        beat(1'b1, 4'd1, 2'b10, 8'h00, 8'h66, 1'b0);
        chk("last_beat_ce", 32'(alu_ce), 32'd1);
        chk("last_beat_err", 32'(err_timeout), 32'd0);
        chk("last_beat_opb", 32'(alu_opb), 32'h66);
        idle(2);

        phase = "illegal";
        beat(1'b0, 4'd14, 2'b11, 8'h01, 8'h02, 1'b0);
        chk("illegal_errcmd", 32'(err_cmd), 32'd1);
        chk("illegal_ce", 32'(alu_ce), 32'd0);
        idle(1);

        phase = "mode_change";
        beat(1'b1, 4'd2, 2'b01, 8'h21, 8'h00, 1'b1);
        idle(1);
        beat(1'b0, 4'd2, 2'b10, 8'h00, 8'h43, 1'b0);
        chk("mode_change_err", 32'(err_timeout), 32'd1);
        chk("mode_change_busy", 32'(busy), 32'd0);
        chk("mode_change_ce", 32'(alu_ce), 32'd0);
        idle(1);

        phase = "mid_reset";
        beat(1'b1, 4'd2, 2'b01, 8'h21, 8'h00, 1'b1);
        idle(2);
        rst = 1'b0;
        cyc();
        chk("mid_reset_outputs",
            32'({alu_ce, alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
                 alu_cin, busy, err_timeout, err_cmd}), 32'd0);
        rst = 1'b1;
        beat(1'b1, 4'd0, 2'b11, 8'h11, 8'h22, 1'b1);
        chk("post_reset_ce", 32'(alu_ce), 32'd1);
        chk("post_reset_opa", 32'(alu_opa), 32'h11);
        chk("post_reset_err", 32'({err_timeout, err_cmd}), 32'd0);
        idle(1);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            in_mode      = 1'($urandom);
            in_cmd       = 4'($urandom);
            in_inp_valid = 2'($urandom);
            in_opa       = 8'($urandom);
            in_opb       = 8'($urandom);
            in_cin       = 1'($urandom);
            if (r < 2) begin
                rst = 1'b0;
                in_ce = 1'($urandom);
                cyc();
                rst = 1'b1;
                in_ce = 1'b0;
            end else if (r < 40) begin
                idle(($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 18)) : 1);
            end else begin
                if (p_act && $urandom_range(0, 4) != 0) begin
                    in_mode = p_mode;
                    in_cmd  = p_cmd;
                end
                beat(in_mode, in_cmd, in_inp_valid, in_opa, in_opb, in_cin);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
